// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating confidence counters
// and a one-entry-per-cycle invalidate sweep that also serves as reset initialisation.
module branch_target_predictor #(
  parameter int PC_WIDTH     = 16,
  parameter int INDEX_BITS   = 10,
  parameter int TAG_BITS     = 5,
  parameter int COUNTER_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_hit,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  input  logic                inv_all,
  output logic                busy
);

  localparam int DEPTH = 1 << INDEX_BITS;
  // Counter storage keeps one bit even in last-target mode; it is never consulted there.
  localparam int CW = (COUNTER_BITS == 0) ? 1 : COUNTER_BITS;
  localparam logic [CW-1:0] CNT_INIT = CW'(1) << (CW - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                  state, state_next;
  logic [INDEX_BITS-1:0]   sweep_idx, sweep_idx_next;

  logic [DEPTH-1:0]        valid_mem;
  logic [TAG_BITS-1:0]     tag_mem    [DEPTH];
  logic [PC_WIDTH-1:0]     target_mem [DEPTH];
  logic [CW-1:0]           cnt_mem    [DEPTH];

  logic [INDEX_BITS-1:0]   l_idx, u_idx;
  logic [TAG_BITS-1:0]     l_tag, u_tag;
  logic                    l_strong, u_match, upd_accept;

  assign busy = (state == SWEEP);

  assign l_idx    = lookup_pc[INDEX_BITS:1];
  assign l_tag    = lookup_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
  assign l_strong = (COUNTER_BITS == 0) ? 1'b1 : cnt_mem[l_idx][CW-1];
  assign pred_hit = !busy && valid_mem[l_idx] && (tag_mem[l_idx] == l_tag) && l_strong;
  assign pred_pc  = pred_hit ? target_mem[l_idx] : lookup_pc + PC_WIDTH'(2);

  assign u_idx      = upd_pc[INDEX_BITS:1];
  assign u_tag      = upd_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
  assign u_match    = valid_mem[u_idx] && (tag_mem[u_idx] == u_tag);
  assign upd_accept = upd_valid && (state == IDLE) && !inv_all;

  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    case (state)
      IDLE: begin
        if (inv_all) begin
          state_next     = SWEEP;
          sweep_idx_next = '0;
        end
      end
      SWEEP: begin
        if (inv_all) begin
          sweep_idx_next = '0;
        end else begin
          sweep_idx_next = sweep_idx + INDEX_BITS'(1);
          if (&sweep_idx) state_next = IDLE;
        end
      end
      default: begin
        state_next     = SWEEP;
        sweep_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SWEEP;
      sweep_idx <= '0;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_idx_next;
    end
  end

  // Table storage has no reset: the sweep clears every valid bit before any lookup can hit.
  always_ff @(posedge clk) begin
    if (state == SWEEP) begin
      valid_mem[sweep_idx] <= 1'b0;
    end else if (upd_accept) begin
      if (u_match) begin
        if (upd_taken) begin
          target_mem[u_idx] <= upd_target;
          if (cnt_mem[u_idx] != '1) cnt_mem[u_idx] <= cnt_mem[u_idx] + CW'(1);
        end else if (cnt_mem[u_idx] != '0) begin
          cnt_mem[u_idx] <= cnt_mem[u_idx] - CW'(1);
        end
      end else if (upd_taken) begin
        valid_mem[u_idx]  <= 1'b1;
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= upd_target;
        cnt_mem[u_idx]    <= CNT_INIT;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed bench: a default-parameter instance and a last-target-mode
// instance share stimulus and are compared against an array-based reference model.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lookup_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, inv_all;
  logic [15:0] pred_pc, pred_pc_c0;
  logic        pred_hit, pred_hit_c0, busy, busy_c0;

  int checks = 0;
  int failures = 0;

  // Reference model: valid/tag/target evolve identically in both modes; only confidence differs.
  bit mv [1024];
  int mtag [1024];
  int mtgt [1024];
  int mcnt [1024];
  bit m_busy;
  int m_left;

  logic [15:0] g_pc2, g_pc0;
  logic        g_hit2, g_hit0, g_busy;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .inv_all(inv_all), .busy(busy)
  );

  branch_target_predictor #(.COUNTER_BITS(0)) dut_c0 (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_pc(pred_pc_c0), .pred_hit(pred_hit_c0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .inv_all(inv_all), .busy(busy_c0)
  );

  task automatic model_edge(input logic uv, input logic [15:0] upc, input logic ut,
                            input logic [15:0] utgt, input logic inv);
    int i, t;
    if (m_busy) begin
      if (inv) m_left = 1024;
      else begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else if (inv) begin
      m_busy = 1;
      m_left = 1024;
      foreach (mv[k]) mv[k] = 0;
    end else if (uv) begin
      i = (int'(upc) / 2) % 1024;
      t = (int'(upc) / 2048) % 32;
      if (mv[i] && mtag[i] == t) begin
        if (ut) begin
          mtgt[i] = int'(utgt);
          if (mcnt[i] < 3) mcnt[i]++;
        end else if (mcnt[i] > 0) mcnt[i]--;
      end else if (ut) begin
        mv[i] = 1; mtag[i] = t; mtgt[i] = int'(utgt); mcnt[i] = 2;
      end
    end
  endtask

  task automatic cycle(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                       input logic ut, input logic [15:0] utgt, input logic inv);
    int i, t;
    bit base, h2;
    logic [15:0] e2, e0, seq;
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; inv_all = inv;
    @(negedge clk);
    i = (int'(lpc) / 2) % 1024;
    t = (int'(lpc) / 2048) % 32;
    base = !m_busy && mv[i] && mtag[i] == t;
    h2 = base && mcnt[i] >= 2;
    seq = 16'((int'(lpc) + 2) % 65536);
    e2 = h2 ? 16'(mtgt[i]) : seq;
    e0 = base ? 16'(mtgt[i]) : seq;
    g_pc2 = pred_pc; g_hit2 = pred_hit; g_pc0 = pred_pc_c0; g_hit0 = pred_hit_c0; g_busy = busy;
    checks += 6;
    if (busy !== m_busy) begin failures++; $display("FAIL busy got %b exp %b", busy, m_busy); end
    if (busy_c0 !== m_busy) begin failures++; $display("FAIL busy_c0 got %b exp %b", busy_c0, m_busy); end
    if (pred_hit !== h2) begin failures++; $display("FAIL pred_hit lpc=%h got %b exp %b", lpc, pred_hit, h2); end
    if (pred_pc !== e2) begin failures++; $display("FAIL pred_pc lpc=%h got %h exp %h", lpc, pred_pc, e2); end
    if (pred_hit_c0 !== base) begin failures++; $display("FAIL pred_hit_c0 lpc=%h got %b exp %b", lpc, pred_hit_c0, base); end
    if (pred_pc_c0 !== e0) begin failures++; $display("FAIL pred_pc_c0 lpc=%h got %h exp %h", lpc, pred_pc_c0, e0); end
    @(posedge clk);
    model_edge(uv, upc, ut, utgt, inv);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    checks += 4;
    if (busy !== 1'b1 || busy_c0 !== 1'b1) begin
      failures++; $display("FAIL reset_busy got %b/%b exp 1", busy, busy_c0);
    end
    if (pred_hit !== 1'b0 || pred_hit_c0 !== 1'b0) begin
      failures++; $display("FAIL reset_hit got %b/%b exp 0", pred_hit, pred_hit_c0);
    end
    if (pred_pc !== lookup_pc + 16'd2) begin
      failures++; $display("FAIL reset_pred_pc got %h exp %h", pred_pc, lookup_pc + 16'd2);
    end
    if (pred_pc_c0 !== lookup_pc + 16'd2) begin
      failures++; $display("FAIL reset_pred_pc_c0 got %h exp %h", pred_pc_c0, lookup_pc + 16'd2);
    end
    m_busy = 1; m_left = 1024;
    foreach (mv[k]) mv[k] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs until the DUT reports idle (bounded) and returns how many cycles it was busy.
  task automatic count_busy(input logic [15:0] lpc, output int n);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      cycle(lpc, 1'b1, lpc, 1'b1, 16'($urandom), 1'b0);
      if (g_busy) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n;
    lookup_pc = 16'h0040;
    do_reset();
    count_busy(16'h0040, n);
    checks++;
    if (n != 1024) begin failures++; $display("FAIL reset_sweep_len got %0d exp 1024", n); end
    // The update in the first idle cycle allocated 0x0040; clear it via a full invalidate later.
    cycle(16'hFFFE, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0000 || g_hit2 !== 1'b0) begin
      failures++; $display("FAIL wrap got %h/%b exp 0000/0", g_pc2, g_hit2);
    end
  endtask

  task automatic test_counter();
    int n;
    cycle(16'h0000, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    count_busy(16'h0040, n);
    cycle(16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0200 || g_hit2 !== 1'b1) begin
      failures++; $display("FAIL alloc_hit got %h/%b exp 0200/1", g_pc2, g_hit2);
    end
    cycle(16'h0900, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0902 || g_hit2 !== 1'b0) begin
      failures++; $display("FAIL tag_miss got %h/%b exp 0902/0", g_pc2, g_hit2);
    end
    cycle(16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0102 || g_hit2 !== 1'b0 || g_pc0 !== 16'h0200 || g_hit0 !== 1'b1) begin
      failures++; $display("FAIL weak got %h/%b c0 %h/%b exp 0102/0 c0 0200/1", g_pc2, g_hit2, g_pc0, g_hit0);
    end
    repeat (2) cycle(16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0200 || g_hit2 !== 1'b1) begin
      failures++; $display("FAIL strong got %h/%b exp 0200/1", g_pc2, g_hit2);
    end
    repeat (3) cycle(16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    cycle(16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc2 !== 16'h0102 || g_hit2 !== 1'b0) begin
      failures++; $display("FAIL sat_low got %h/%b exp 0102/0", g_pc2, g_hit2);
    end
  endtask

  task automatic test_last_target();
    cycle(16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0300, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc0 !== 16'h0300 || g_hit0 !== 1'b1 || g_pc2 !== 16'h0300 || g_hit2 !== 1'b1) begin
      failures++; $display("FAIL retarget got %h/%b c0 %h/%b exp 0300/1", g_pc2, g_hit2, g_pc0, g_hit0);
    end
    cycle(16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0, 1'b0);
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (g_pc0 !== 16'h0300 || g_hit0 !== 1'b1 || g_hit2 !== 1'b0) begin
      failures++; $display("FAIL c0_not_taken got c0 %h/%b c2 hit %b exp 0300/1 hit 0", g_pc0, g_hit0, g_hit2);
    end
  endtask

  task automatic test_invalidate();
    int n;
    cycle(16'h0100, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 1100; k++) begin
      cycle(16'h0100, 1'b1, 16'h0100, 1'b1, 16'h0700, 1'b0);
      if (!g_busy) begin
        checks++;
        if (g_pc2 !== 16'h0102 || g_hit2 !== 1'b0 || g_pc0 !== 16'h0102 || g_hit0 !== 1'b0) begin
          failures++; $display("FAIL post_inv got %h/%b c0 %h/%b exp 0102/0", g_pc2, g_hit2, g_pc0, g_hit0);
        end
        break;
      end
      n++;
    end
    checks++;
    if (n != 1024) begin failures++; $display("FAIL inv_sweep_len got %0d exp 1024", n); end
    // Update coinciding with the invalidate request is dropped.
    cycle(16'h0200, 1'b1, 16'h0200, 1'b1, 16'h0AAA, 1'b1);
    count_busy(16'h0200, n);
    checks++;
    if (g_pc2 !== 16'h0202 || g_hit2 !== 1'b0) begin
      failures++; $display("FAIL inv_wins got %h/%b exp 0202/0", g_pc2, g_hit2);
    end
  endtask

  function automatic logic [15:0] pool_pc();
    return 16'(($urandom % 4) * 2048 + ($urandom % 8) * 2 + ($urandom % 2));
  endfunction

  task automatic test_random();
    logic [15:0] lpc;
    int n;
    for (int k = 0; k < 3000; k++) begin
      lpc = ($urandom % 4 != 0) ? pool_pc() : 16'($urandom);
      cycle(lpc, 1'($urandom), pool_pc(), 1'($urandom), 16'($urandom), 1'b0);
      if (k == 1500) begin
        cycle(pool_pc(), 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        repeat (300) cycle(pool_pc(), 1'($urandom), pool_pc(), 1'b1, 16'($urandom), 1'b0);
        cycle(pool_pc(), 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
        repeat (200) cycle(pool_pc(), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        do_reset();
        count_busy(pool_pc(), n);
        checks++;
        if (n != 1024) begin failures++; $display("FAIL midsweep_reset_len got %0d exp 1024", n); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; inv_all = 1'b0;
    foreach (mv[k]) begin mv[k] = 0; mtag[k] = 0; mtgt[k] = 0; mcnt[k] = 0; end
    #2;
    test_reset();
    test_counter();
    test_last_target();
    test_invalidate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16: width of PC and target fields.
REQ-002 SHALL have parameter INDEX_BITS, default 10: table depth is 2^INDEX_BITS entries.
REQ-003 SHALL have parameter TAG_BITS, default 5: tag width, with INDEX_BITS+TAG_BITS+1 <= PC_WIDTH.
REQ-004 SHALL have parameter COUNTER_BITS, default 2: saturating-counter width; 0 selects last-target mode with no counter.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port lookup_pc, input, PC_WIDTH, fetch PC to predict.
REQ-008 SHALL have port pred_pc, output, PC_WIDTH, predicted next PC.
REQ-009 SHALL have port pred_hit, output, 1, high when pred_pc came from the table.
REQ-010 SHALL have port upd_valid, input, 1, resolved-branch update strobe.
REQ-011 SHALL have ports upd_pc (input, PC_WIDTH), upd_taken (input, 1) and upd_target (input, PC_WIDTH), carrying the resolved branch PC, its outcome and its target.
REQ-012 SHALL have port inv_all, input, 1, request to invalidate the whole table.
REQ-013 SHALL have port busy, output, 1, high while an invalidate sweep runs.

Function
REQ-014 Entry SHALL hold valid, tag, target and counter; index = pc[INDEX_BITS:1], tag = pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1]; pc[0] ignored.
REQ-015 Lookup SHALL be combinational; hit = !busy & valid & tag match & (COUNTER_BITS==0 | counter MSB==1).
REQ-016 On hit: pred_pc = stored target, pred_hit = 1; otherwise pred_pc = lookup_pc+2 modulo 2^PC_WIDTH, pred_hit = 0.
REQ-017 Update SHALL be accepted only when upd_valid=1 and busy=0; updates during busy are dropped.
REQ-018 Update, entry matches (valid & tag equal), taken: counter saturating +1, target <= upd_target.
REQ-019 Update, entry matches, not taken: counter saturating -1; valid, tag and target unchanged.
REQ-020 Update, no match, taken: allocate (overwrite) with valid=1, new tag, target, counter = 2^(COUNTER_BITS-1).
REQ-021 Update, no match, not taken: no state change.
REQ-022 Updates SHALL be visible to lookups from the next cycle; same-cycle lookup sees old contents (no bypass).
REQ-023 COUNTER_BITS=0: taken update writes valid/tag/target; not-taken update changes nothing.
REQ-024 FSM states IDLE and SWEEP; SWEEP clears valid at sweep index each cycle, index incrementing from 0.
REQ-025 SWEEP -> IDLE on the edge that clears entry 2^INDEX_BITS-1; busy = (state==SWEEP).
REQ-026 inv_all in IDLE SHALL enter SWEEP at index 0 next edge; inv_all during SWEEP restarts at index 0.
REQ-027 upd_valid simultaneous with inv_all in IDLE SHALL be dropped; the invalidate wins.

Reset
REQ-028 rst=1 SHALL immediately force state SWEEP, sweep index 0, busy=1, pred_hit=0, pred_pc=lookup_pc+2.
REQ-029 After rst deasserts, the sweep SHALL take exactly 2^INDEX_BITS edges; table contents need no reset value.
REQ-030 rst asserted mid-sweep SHALL restart the sweep at index 0.

Verification (defaults unless stated)
REQ-031 Pulse rst -> busy high for exactly 1024 edges after deassert; lookup 0x0040 meanwhile gives pred_pc 0x0042, hit 0.
REQ-032 After sweep, update pc 0x0100 taken target 0x0200 -> next cycle lookup 0x0100 gives 0x0200 hit 1; lookup 0x0900 (same index, tag 1) gives 0x0902 hit 0.
REQ-033 From REQ-032 state: one not-taken -> 0x0100 predicts 0x0102 hit 0; then two taken -> hit 1 (counter 3); then three not-taken, one taken -> counter 1, hit 0.
REQ-034 COUNTER_BITS=0: taken 0x0100->0x0200, then taken 0x0100->0x0300 -> predicts 0x0300; not-taken update -> still 0x0300 hit 1.
REQ-035 inv_all with entries present -> busy 1024 edges; upd_valid during sweep ignored; afterwards lookup 0x0100 gives 0x0102 hit 0.
REQ-036 Lookup 0xFFFE on empty table -> pred_pc 0x0000, hit 0 (wrap-around).
